// File: rtl/rho_stage_if.sv
// Slice-stream interface around the rho stage: input slice handshake,
// output slice handshake and status.
interface rho_stage_if;
  logic        inValid;
  logic [24:0] sliceIn;
  logic        inReady;
  logic        outValid;
  logic [24:0] sliceOut;
  logic        outAccept;
  logic        outLast;
  logic        busy;

  // Upstream/downstream side (drives slices in, accepts slices out)
  modport master (
    output inValid, sliceIn, outAccept,
    input  inReady, outValid, sliceOut, outLast, busy
  );

  // Rho stage side
  modport slave (
    input  inValid, sliceIn, outAccept,
    output inReady, outValid, sliceOut, outLast, busy
  );
endinterface

// File: rtl/rho_stage.sv
// Keccak rho step on a slice stream. Captures a full 64-slice state into
// 25 lane registers, then replays it slice by slice with each lane rotated
// by its fixed rho offset. Rotation crosses slices, so the whole state is
// held before the first output.
//
// state | meaning
// IDLE  | waiting for slice z=0 of a new state
// LOAD  | capturing slices 1..63
// EMIT  | presenting rotated slices, count advances on outAccept
module rho_stage (
  input  logic         clk,
  input  logic         rst,
  rho_stage_if.slave   bus
);

  localparam int SLICES = 64;
  localparam int WIDTH  = 25;

  // Rho offset per lane, indexed by bit i = 5*y + x
  localparam logic [5:0] ROT [WIDTH] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,   // y=0
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,   // y=1
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,   // y=2
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,    // y=3
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14    // y=4
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [5:0]          r_cnt;
  logic [5:0]          w_cnt_nxt;
  logic [SLICES-1:0]   r_lane [WIDTH];
  logic                w_wr;
  logic [WIDTH-1:0]    w_rot;

  // State and slice counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    bus.inReady  = 1'b0;
    bus.outValid = 1'b0;
    bus.busy     = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        bus.inReady = 1'b1;
        if (bus.inValid) begin
          w_cnt_nxt   = 6'd1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        bus.inReady = 1'b1;
        if (bus.inValid) begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            w_state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        bus.outValid = 1'b1;
        if (bus.outAccept) begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 6'd0;
      end
    endcase
  end

  assign w_wr = bus.inValid && bus.inReady;

  // Lane storage: bit i of an accepted slice lands in lane i at bit z.
  // Contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_lane[i][r_cnt] <= bus.sliceIn[i];
      end
    end
  end

  // Rotated slice for z = count: lane bit (z - offset) mod 64, the 6-bit
  // wrap of the subtraction doing the modulo
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rot[i] = r_lane[i][6'(r_cnt - ROT[i])];
    end
  end

  assign bus.sliceOut = bus.outValid ? w_rot : '0;
  assign bus.outLast  = bus.outValid && (r_cnt == 6'd63);

endmodule

// File: tb/tb_rho_stage.sv
// Bench for rho_stage: directed and random states against a lane/offset
// reference model, with input gaps, output stalls and mid-load reset.
module tb_rho_stage;

  logic clk;
  logic rst;
  rho_stage_if bus ();

  rho_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Rho offsets written as R[x][y]
  int R [5][5] = '{
    '{0, 36, 3, 41, 18},
    '{1, 44, 10, 45, 2},
    '{62, 6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39, 8, 14}
  };

  logic [24:0] st  [64];
  logic [24:0] exp_out [64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: view the state as lanes A[x][y][z], rotate each lane by
  // R[x][y] toward higher z, then re-slice.
  task automatic model();
    bit lanes [5][5][64];
    for (int z = 0; z < 64; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          lanes[x][y][z] = st[z][5*y + x];
    for (int z = 0; z < 64; z++) begin
      exp_out[z] = '0;
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          exp_out[z][5*y + x] = lanes[x][y][(z - R[x][y] + 64) % 64];
    end
  endtask

  // Stream st[] in (optionally every other cycle), then drain all outputs
  // (optionally stalling 3 cycles at slice stall_at) against the model.
  task automatic run_state(input string name, input bit in_gap, input int stall_at);
    int idx;
    int cyc;
    int z;
    int stall;
    bit tog;
    model();
    idx = 0; cyc = 0; tog = 1'b0;
    while (idx < 64 && cyc < 1000) begin
      @(negedge clk);
      check({name, ".ld_ready"}, 64'(bus.inReady), 64'd1);
      check({name, ".ld_valid"}, 64'(bus.outValid), 64'd0);
      if (in_gap && tog) begin
        bus.inValid = 1'b0;
        bus.sliceIn = 25'($urandom);
      end else begin
        bus.inValid = 1'b1;
        bus.sliceIn = st[idx];
        idx++;
      end
      bus.outAccept = 1'($urandom);
      tog = !tog;
      cyc++;
    end
    @(negedge clk);
    z = 0; stall = 0; cyc = 0;
    while (z < 64 && cyc < 500) begin
      check({name, ".valid"}, 64'(bus.outValid), 64'd1);
      check({name, ".ready"}, 64'(bus.inReady), 64'd0);
      check({name, ".busy"}, 64'(bus.busy), 64'd1);
      check($sformatf("%s.slice%0d", name, z), 64'(bus.sliceOut), 64'(exp_out[z]));
      check({name, ".last"}, 64'(bus.outLast), 64'(z == 63));
      if (z == stall_at && stall < 3) begin
        bus.outAccept = 1'b0;
        stall++;
      end else begin
        bus.outAccept = 1'b1;
        z++;
      end
      bus.inValid = 1'($urandom);
      bus.sliceIn = 25'($urandom);
      @(negedge clk);
      cyc++;
    end
    check({name, ".emit_done"}, 64'(z), 64'd64);
    check({name, ".idle_ready"}, 64'(bus.inReady), 64'd1);
    check({name, ".idle_valid"}, 64'(bus.outValid), 64'd0);
    check({name, ".idle_busy"}, 64'(bus.busy), 64'd0);
    check({name, ".idle_out"}, 64'(bus.sliceOut), 64'd0);
    bus.inValid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;

    // Reset held 2 cycles with random inputs
    rst = 1'b1;
    bus.inValid = 1'($urandom);
    bus.sliceIn = 25'($urandom);
    bus.outAccept = 1'($urandom);
    repeat (2) begin
      @(negedge clk);
      bus.inValid = 1'($urandom);
      bus.sliceIn = 25'($urandom);
      bus.outAccept = 1'($urandom);
    end
    rst = 1'b0;
    bus.inValid = 1'b0;
    check("rst.ready", 64'(bus.inReady), 64'd1);
    check("rst.valid", 64'(bus.outValid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.out", 64'(bus.sliceOut), 64'd0);
    check("rst.last", 64'(bus.outLast), 64'd0);

    // Identity lane and unit shift
    foreach (st[i]) st[i] = '0;
    st[0] = 25'h1;
    run_state("id", 1'b0, -1);
    foreach (st[i]) st[i] = '0;
    st[0] = 25'h2;
    run_state("unit", 1'b0, -1);

    // Wrap-around: lane (2,0), r=62, z=5 -> z=3
    foreach (st[i]) st[i] = '0;
    st[5] = 25'h4;
    run_state("wrap", 1'b0, -1);

    foreach (st[i]) st[i] = 25'h1FFFFFF;
    run_state("ones", 1'b0, -1);
    foreach (st[i]) st[i] = (i % 2 == 0) ? 25'h1555555 : 25'h0AAAAAA;
    run_state("alt", 1'b0, -1);

    // Handshake: gapped input, stalled output
    foreach (st[i]) st[i] = 25'($urandom);
    run_state("gap", 1'b1, -1);
    foreach (st[i]) st[i] = 25'($urandom);
    run_state("stall", 1'b0, 10);

    // Reset after 30 slices of a load, then a clean state
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.inValid = 1'b1;
      bus.sliceIn = 25'h1FFFFFF;
    end
    @(negedge clk);
    bus.inValid = 1'b0;
    check("abort.busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.ready", 64'(bus.inReady), 64'd1);
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.valid", 64'(bus.outValid), 64'd0);
    foreach (st[i]) st[i] = 25'($urandom) & 25'h0F0F0F0;
    run_state("post_abort", 1'b0, 20);

    foreach (st[i]) st[i] = 25'($urandom);
    run_state("rand", 1'b1, 63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
